// File: rtl/oy_toplayici.sv
// ----------------------------------------------------------------------------
// oy_toplayici
//
// Serial ballot collector. One voter's road-length pair arrives per
// valid/ready handshake and is turned into a single preference bit
// (asphalt wins when its length is not longer than the stone road). After
// SECMEN_SAYISI accepted votes, the majority decision and the asphalt vote
// count are registered and held on a valid/ready result interface until the
// consumer takes them.
//
// Parameters:
//   SECMEN_SAYISI  voters per election (odd, >= 1)
//   UZ_W           width of each road-length input
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   baslat          start-election request, honoured only while idle
//   iptal           abort the running collection, discarding its votes
//   oy_gecerli      voter data valid
//   oy_hazir        collector ready for a vote (high only while collecting)
//   tasli_uzunluk   stone-road length of the current voter
//   asfalt_uzunluk  asphalt-road length of the current voter
//   sonuc_gecerli   majority result valid, held until consumed
//   sonuc_hazir     consumer accepts the result
//   sonuc           1 = majority prefers asphalt
//   evet_sayisi     number of asphalt votes in the finished election
// ----------------------------------------------------------------------------
module oy_toplayici #(
    parameter int SECMEN_SAYISI = 3,
    parameter int UZ_W          = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   baslat,
    input  logic                                   iptal,
    input  logic                                   oy_gecerli,
    output logic                                   oy_hazir,
    input  logic [UZ_W-1:0]                        tasli_uzunluk,
    input  logic [UZ_W-1:0]                        asfalt_uzunluk,
    output logic                                   sonuc_gecerli,
    input  logic                                   sonuc_hazir,
    output logic                                   sonuc,
    output logic [$clog2(SECMEN_SAYISI+1)-1:0]     evet_sayisi
);

    localparam int SAY_W = $clog2(SECMEN_SAYISI + 1);

    // Count value held just before the final vote, and the majority
    // threshold (strictly more than half of an odd electorate).
    localparam logic [SAY_W-1:0] SON_ONCESI = SAY_W'(SECMEN_SAYISI - 1);
    localparam logic [SAY_W-1:0] YARI       = SAY_W'(SECMEN_SAYISI / 2);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        TOPLA = 2'd1,
        SONUC = 2'd2
    } durum_t;

    durum_t             durum;
    durum_t             durum_next;
    logic [SAY_W-1:0]   sayac;
    logic [SAY_W-1:0]   evet;
    logic [SAY_W-1:0]   evet_yeni;
    logic               oy;
    logic               kabul;
    logic               son_kabul;

    // Ready is a pure state decode so a vote can be taken on the very first
    // collecting cycle and on every consecutive one.
    assign oy_hazir  = (durum == TOPLA);

    // Equal lengths favour asphalt.
    assign oy        = (asfalt_uzunluk <= tasli_uzunluk);
    assign kabul     = oy_gecerli & oy_hazir;
    assign evet_yeni = evet + SAY_W'(oy);

    // Abort outranks the vote offered in the same cycle, so the closing
    // vote must also be free of iptal.
    assign son_kabul = kabul & ~iptal & (sayac == SON_ONCESI);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: durum_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        durum_next = durum;
        unique case (durum)
            BOSTA: begin
                if (baslat) begin
                    durum_next = TOPLA;
                end
            end
            TOPLA: begin
                if (iptal) begin
                    durum_next = BOSTA;
                end else if (son_kabul) begin
                    durum_next = SONUC;
                end
            end
            SONUC: begin
                // baslat and iptal are deliberately not looked at here.
                if (sonuc_hazir) begin
                    durum_next = BOSTA;
                end
            end
            default: durum_next = BOSTA;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and registered result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sayac         <= '0;
            evet          <= '0;
            sonuc_gecerli <= 1'b0;
            sonuc         <= 1'b0;
            evet_sayisi   <= '0;
        end else begin
            unique case (durum)
                BOSTA: begin
                    // Result registers keep the previous election's outcome.
                    if (baslat) begin
                        sayac <= '0;
                        evet  <= '0;
                    end
                end
                TOPLA: begin
                    if (iptal) begin
                        sayac <= '0;
                        evet  <= '0;
                    end else if (kabul) begin
                        sayac <= sayac + SAY_W'(1);
                        evet  <= evet_yeni;
                        // The closing vote is folded in directly so the
                        // result appears the cycle after it is accepted.
                        if (son_kabul) begin
                            evet_sayisi   <= evet_yeni;
                            sonuc         <= (evet_yeni > YARI);
                            sonuc_gecerli <= 1'b1;
                        end
                    end
                end
                SONUC: begin
                    if (sonuc_hazir) begin
                        sonuc_gecerli <= 1'b0;
                    end
                end
                default: begin
                    sonuc_gecerli <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oy_toplayici.sv
// ----------------------------------------------------------------------------
// tb_oy_toplayici
//
// Directed bench for oy_toplayici. A three-voter instance carries most
// scenarios; a five-voter instance covers the wider electorate. Inputs are
// driven 1 time unit after a rising edge; outputs are checked at that same
// point, i.e. after the edge has settled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oy_toplayici;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Three-voter instance
    logic       baslat, iptal, oy_gecerli, sonuc_hazir;
    logic [2:0] tasli, asfalt;
    logic       oy_hazir, sonuc_gecerli, sonuc;
    logic [1:0] evet_sayisi;

    // Five-voter instance
    logic       baslat5, iptal5, oy_gecerli5, sonuc_hazir5;
    logic [2:0] tasli5, asfalt5;
    logic       oy_hazir5, sonuc_gecerli5, sonuc5;
    logic [2:0] evet_sayisi5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    oy_toplayici #(.SECMEN_SAYISI(3), .UZ_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .baslat         (baslat),
        .iptal          (iptal),
        .oy_gecerli     (oy_gecerli),
        .oy_hazir       (oy_hazir),
        .tasli_uzunluk  (tasli),
        .asfalt_uzunluk (asfalt),
        .sonuc_gecerli  (sonuc_gecerli),
        .sonuc_hazir    (sonuc_hazir),
        .sonuc          (sonuc),
        .evet_sayisi    (evet_sayisi)
    );

    oy_toplayici #(.SECMEN_SAYISI(5), .UZ_W(3)) dut5 (
        .clk            (clk),
        .rst            (rst),
        .baslat         (baslat5),
        .iptal          (iptal5),
        .oy_gecerli     (oy_gecerli5),
        .oy_hazir       (oy_hazir5),
        .tasli_uzunluk  (tasli5),
        .asfalt_uzunluk (asfalt5),
        .sonuc_gecerli  (sonuc_gecerli5),
        .sonuc_hazir    (sonuc_hazir5),
        .sonuc          (sonuc5),
        .evet_sayisi    (evet_sayisi5)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_election();
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
    endtask

    task automatic send_vote(input logic [2:0] t, input logic [2:0] a);
        oy_gecerli = 1'b1;
        tasli      = t;
        asfalt     = a;
        tick();
        oy_gecerli = 1'b0;
    endtask

    task automatic consume();
        sonuc_hazir = 1'b1;
        tick();
        sonuc_hazir = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({oy_hazir, sonuc_gecerli, sonuc, evet_sayisi} !== 5'b0) begin
            errors++;
            $display("FAIL reset3: got hazir=%b gecerli=%b sonuc=%b evet=%0d, want all 0",
                     oy_hazir, sonuc_gecerli, sonuc, evet_sayisi);
        end
        checks++;
        if ({oy_hazir5, sonuc_gecerli5, sonuc5, evet_sayisi5} !== 6'b0) begin
            errors++;
            $display("FAIL reset5: got hazir=%b gecerli=%b sonuc=%b evet=%0d, want all 0",
                     oy_hazir5, sonuc_gecerli5, sonuc5, evet_sayisi5);
        end
        #9 rst = 1'b0;
        tick();
        checks++;
        if (oy_hazir !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: oy_hazir=%b, want 0", oy_hazir);
        end
    endtask

    task automatic test_basic_vote();
        start_election();
        checks++;
        if (oy_hazir !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_start: oy_hazir=%b, want 1", oy_hazir);
        end
        // (5,2)->1 (1,4)->0 (3,3)->1, sent back to back
        send_vote(3'd5, 3'd2);
        send_vote(3'd1, 3'd4);
        checks++;
        if (oy_hazir !== 1'b1 || sonuc_gecerli !== 1'b0) begin
            errors++;
            $display("FAIL after_two_votes: hazir=%b gecerli=%b, want 1 0", oy_hazir, sonuc_gecerli);
        end
        send_vote(3'd3, 3'd3);
        checks++;
        if ({oy_hazir, sonuc_gecerli, sonuc, evet_sayisi} !== {1'b0, 1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL basic_result: hazir=%b gecerli=%b sonuc=%b evet=%0d, want 0 1 1 2",
                     oy_hazir, sonuc_gecerli, sonuc, evet_sayisi);
        end
        consume();
        checks++;
        if ({oy_hazir, sonuc_gecerli, sonuc, evet_sayisi} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL basic_consumed: hazir=%b gecerli=%b sonuc=%b evet=%0d, want 0 0 1 2",
                     oy_hazir, sonuc_gecerli, sonuc, evet_sayisi);
        end
    endtask

    task automatic test_hold_result();
        start_election();
        // (0,7)->0 (2,3)->0 (6,1)->1
        send_vote(3'd0, 3'd7);
        send_vote(3'd2, 3'd3);
        send_vote(3'd6, 3'd1);
        // baslat and iptal are offered while the result waits; both ignored
        baslat = 1'b1;
        iptal  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({oy_hazir, sonuc_gecerli, sonuc, evet_sayisi} !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
                errors++;
                $display("FAIL hold_cycle%0d: hazir=%b gecerli=%b sonuc=%b evet=%0d, want 0 1 0 1",
                         i, oy_hazir, sonuc_gecerli, sonuc, evet_sayisi);
            end
            tick();
        end
        iptal = 1'b0;
        // consume with baslat still high in the same cycle
        consume();
        baslat = 1'b0;
        checks++;
        if ({oy_hazir, sonuc_gecerli} !== 2'b00) begin
            errors++;
            $display("FAIL hold_consumed: hazir=%b gecerli=%b, want 0 0", oy_hazir, sonuc_gecerli);
        end
        tick();
        checks++;
        if (oy_hazir !== 1'b0) begin
            errors++;
            $display("FAIL baslat_in_sonuc_ignored: oy_hazir=%b, want 0", oy_hazir);
        end
    endtask

    task automatic test_gapped_valid();
        logic [4:0] desen;
        desen = 5'b10101;
        start_election();
        tasli  = 3'd5;
        asfalt = 3'd1;
        for (int i = 4; i >= 0; i--) begin
            oy_gecerli = desen[i];
            tick();
            if (i == 1) begin
                checks++;
                if (oy_hazir !== 1'b1 || sonuc_gecerli !== 1'b0) begin
                    errors++;
                    $display("FAIL gapped_mid: hazir=%b gecerli=%b, want 1 0", oy_hazir, sonuc_gecerli);
                end
            end
        end
        oy_gecerli = 1'b0;
        checks++;
        if ({sonuc_gecerli, sonuc, evet_sayisi} !== {1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL gapped_result: gecerli=%b sonuc=%b evet=%0d, want 1 1 3",
                     sonuc_gecerli, sonuc, evet_sayisi);
        end
        consume();
    endtask

    task automatic test_abort();
        start_election();
        send_vote(3'd7, 3'd0);
        send_vote(3'd7, 3'd0);
        // third vote offered together with iptal must not complete the election
        iptal      = 1'b1;
        oy_gecerli = 1'b1;
        tick();
        iptal      = 1'b0;
        oy_gecerli = 1'b0;
        checks++;
        if ({oy_hazir, sonuc_gecerli} !== 2'b00) begin
            errors++;
            $display("FAIL abort_state: hazir=%b gecerli=%b, want 0 0", oy_hazir, sonuc_gecerli);
        end
        tick();
        tick();
        checks++;
        if (sonuc_gecerli !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: gecerli=%b, want 0", sonuc_gecerli);
        end
        start_election();
        send_vote(3'd7, 3'd0);
        send_vote(3'd7, 3'd0);
        checks++;
        if (sonuc_gecerli !== 1'b0) begin
            errors++;
            $display("FAIL abort_counters_cleared: gecerli=%b after 2 votes, want 0", sonuc_gecerli);
        end
        send_vote(3'd7, 3'd0);
        checks++;
        if ({sonuc_gecerli, sonuc, evet_sayisi} !== {1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL abort_rerun: gecerli=%b sonuc=%b evet=%0d, want 1 1 3",
                     sonuc_gecerli, sonuc, evet_sayisi);
        end
        consume();
    endtask

    task automatic test_async_reset();
        start_election();
        send_vote(3'd4, 3'd4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({oy_hazir, sonuc_gecerli, sonuc, evet_sayisi} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: hazir=%b gecerli=%b sonuc=%b evet=%0d, want all 0",
                     oy_hazir, sonuc_gecerli, sonuc, evet_sayisi);
        end
        #2 rst = 1'b0;
        // votes offered without baslat must be refused
        oy_gecerli = 1'b1;
        tick();
        tick();
        oy_gecerli = 1'b0;
        checks++;
        if (oy_hazir !== 1'b0) begin
            errors++;
            $display("FAIL reset_needs_baslat: oy_hazir=%b, want 0", oy_hazir);
        end
        start_election();
        // (1,4)->0 (7,0)->1 (7,0)->1 ; the pre-reset vote is gone
        send_vote(3'd1, 3'd4);
        send_vote(3'd7, 3'd0);
        send_vote(3'd7, 3'd0);
        checks++;
        if ({sonuc_gecerli, sonuc, evet_sayisi} !== {1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL after_reset_result: gecerli=%b sonuc=%b evet=%0d, want 1 1 2",
                     sonuc_gecerli, sonuc, evet_sayisi);
        end
        consume();
    endtask

    task automatic test_five_voters();
        logic [4:0] oylar [2];
        logic [2:0] beklenen_evet [2];
        logic       beklenen_sonuc [2];
        oylar[0] = 5'b11001; beklenen_evet[0] = 3'd3; beklenen_sonuc[0] = 1'b1;
        oylar[1] = 5'b11000; beklenen_evet[1] = 3'd2; beklenen_sonuc[1] = 1'b0;
        for (int e = 0; e < 2; e++) begin
            baslat5 = 1'b1;
            tick();
            baslat5 = 1'b0;
            for (int i = 4; i >= 0; i--) begin
                oy_gecerli5 = 1'b1;
                // asphalt vote: (4,4); stone vote: (1,5)
                tasli5  = oylar[e][i] ? 3'd4 : 3'd1;
                asfalt5 = oylar[e][i] ? 3'd4 : 3'd5;
                tick();
                if (i == 1) begin
                    checks++;
                    if (oy_hazir5 !== 1'b1 || sonuc_gecerli5 !== 1'b0) begin
                        errors++;
                        $display("FAIL five_after4_e%0d: hazir=%b gecerli=%b, want 1 0",
                                 e, oy_hazir5, sonuc_gecerli5);
                    end
                end
            end
            oy_gecerli5 = 1'b0;
            checks++;
            if ({sonuc_gecerli5, sonuc5, evet_sayisi5} !== {1'b1, beklenen_sonuc[e], beklenen_evet[e]}) begin
                errors++;
                $display("FAIL five_result_e%0d: gecerli=%b sonuc=%b evet=%0d, want 1 %b %0d",
                         e, sonuc_gecerli5, sonuc5, evet_sayisi5, beklenen_sonuc[e], beklenen_evet[e]);
            end
            sonuc_hazir5 = 1'b1;
            tick();
            sonuc_hazir5 = 1'b0;
        end
    endtask

    initial begin
        baslat = 1'b0; iptal = 1'b0; oy_gecerli = 1'b0; sonuc_hazir = 1'b0;
        tasli = '0; asfalt = '0;
        baslat5 = 1'b0; iptal5 = 1'b0; oy_gecerli5 = 1'b0; sonuc_hazir5 = 1'b0;
        tasli5 = '0; asfalt5 = '0;
        #1;
        test_reset();
        test_basic_vote();
        test_hold_result();
        test_gapped_valid();
        test_abort();
        test_async_reset();
        test_five_voters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
